// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_ctrl_pkg;

  localparam int REG_NUM_W = 5;
  localparam logic [REG_NUM_W-1:0] ZERO_REG = 5'd0;

  // Fixed state encodings, kept stable for anything that decodes them.
  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_MEM_WAIT = 2'd1;
  localparam logic [1:0] ST_ERROR    = 2'd2;

  typedef enum logic [1:0] {
    RUN      = ST_RUN,
    MEM_WAIT = ST_MEM_WAIT,
    ERROR    = ST_ERROR
  } state_e;

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Load-use hazard compare between the ID instruction and a load in EX.
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [REG_NUM_W-1:0] id_rs_num,
  input  logic [REG_NUM_W-1:0] id_rt_num,
  input  logic                 id_uses_rs,
  input  logic                 id_uses_rt,
  input  logic [REG_NUM_W-1:0] ex_rd_num,
  input  logic                 ex_mem_to_reg,
  input  logic                 ex_reg_write,
  output logic                 load_use
);

  logic rs_hit;
  logic rt_hit;

  assign rs_hit = id_uses_rs && (id_rs_num == ex_rd_num);
  assign rt_hit = id_uses_rt && (id_rt_num == ex_rd_num);

  // Register zero never carries a dependency, so a load targeting it is harmless.
  assign load_use = ex_mem_to_reg && ex_reg_write && (ex_rd_num != ZERO_REG) &&
                    (rs_hit || rt_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for a 5-stage pipeline: load-use bubble, branch
// squash, memory-wait freeze with watchdog, and a stall-cycle counter.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int TIMEOUT_W   = 8,
  parameter int MEM_TIMEOUT = 200,
  parameter int CNT_W       = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [REG_NUM_W-1:0] id_rs_num,
  input  logic [REG_NUM_W-1:0] id_rt_num,
  input  logic                 id_uses_rs,
  input  logic                 id_uses_rt,
  input  logic [REG_NUM_W-1:0] ex_rd_num,
  input  logic                 ex_mem_to_reg,
  input  logic                 ex_reg_write,
  input  logic                 ex_branch_taken,
  input  logic                 mem_req,
  input  logic                 dmem_ready,
  output logic                 dmem_valid,
  output logic                 pc_en,
  output logic                 if_id_en,
  output logic                 if_id_flush,
  output logic                 id_ex_en,
  output logic                 id_ex_flush,
  output logic                 ex_mem_en,
  output logic                 mem_wb_en,
  output logic                 mem_wb_bubble,
  output logic                 mem_error,
  output logic [CNT_W-1:0]     stall_count
);

  // Last wait-counter value before the watchdog fires on the next idle cycle.
  localparam logic [TIMEOUT_W-1:0] WAIT_LAST = TIMEOUT_W'(MEM_TIMEOUT - 1);

  state_e               state_q, state_d;
  logic [TIMEOUT_W-1:0] wait_q, wait_d;
  logic                 err_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 load_use;
  logic                 mem_stall;
  logic                 halt;

  hazard_detect u_hazard_detect (
    .id_rs_num    (id_rs_num),
    .id_rt_num    (id_rt_num),
    .id_uses_rs   (id_uses_rs),
    .id_uses_rt   (id_uses_rt),
    .ex_rd_num    (ex_rd_num),
    .ex_mem_to_reg(ex_mem_to_reg),
    .ex_reg_write (ex_reg_write),
    .load_use     (load_use)
  );

  // Next-state, watchdog and prioritised stage-control decode.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    state_d       = state_q;
    wait_d        = wait_q;
    mem_stall     = 1'b0;
    halt          = 1'b0;
    pc_en         = 1'b1;
    if_id_en      = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_en      = 1'b1;
    id_ex_flush   = 1'b0;
    ex_mem_en     = 1'b1;
    mem_wb_en     = 1'b1;
    mem_wb_bubble = 1'b0;
    dmem_valid    = mem_req;

    case (state_q)
      RUN: begin
        if (mem_req && !dmem_ready) begin
          mem_stall = 1'b1;
          state_d   = MEM_WAIT;
          wait_d    = '0;
        end
      end
      MEM_WAIT: begin
        dmem_valid = 1'b1;
        if (dmem_ready) begin
          // Completion wins over the watchdog, even on the limit cycle.
          state_d = RUN;
          wait_d  = '0;
        end else begin
          mem_stall = 1'b1;
          if (wait_q == WAIT_LAST) state_d = ERROR;
          else                     wait_d  = wait_q + 1'b1;
        end
      end
      default: begin
        // ERROR, and any unreachable encoding, parks the pipeline.
        halt    = 1'b1;
        state_d = ERROR;
      end
    endcase

    if (!rst_n || halt) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_en    = 1'b0;
      ex_mem_en   = 1'b0;
      mem_wb_en   = 1'b0;
      dmem_valid  = 1'b0;
    end else if (mem_stall) begin
      // EX and ID are frozen, so a pending branch or load-use simply waits.
      pc_en         = 1'b0;
      if_id_en      = 1'b0;
      id_ex_en      = 1'b0;
      ex_mem_en     = 1'b0;
      mem_wb_bubble = 1'b1;
      dmem_valid    = 1'b1;
    end else if (ex_branch_taken) begin
      // The ID instruction is wrong-path, so any load-use on it is moot.
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (load_use) begin
      // One bubble suffices: the load reaches MEM next cycle.
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_flush = 1'b1;
    end
  end

  // State, watchdog counter and sticky error register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      wait_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so all registers update together.
      state_q <= state_d;
      wait_q  <= wait_d;
      err_q   <= err_q || (state_d == ERROR);
    end
  end

  // Saturating count of cycles in which the PC was held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (!pc_en && !halt && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign mem_error   = err_q;
  assign stall_count = cnt_q;

endmodule
